ddc_complex_mixer: RTL and testbench

- Digital downconversion mixer. It multiplies real ADC samples by the quadrature local oscillator produced by the upstream NCO to form baseband I/Q.
- Sits between the ADC capture path / NCO and the CIC decimator.
- Three-stage multiply/round/saturate pipeline, followed by a small output FIFO.
- Credit-based in_ready, so no accepted sample is ever lost under downstream backpressure.

---
 rtl/ddc_complex_mixer.sv | 174 +++++++++++++++++
 tb/tb_ddc_complex_mixer.sv | 290 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ddc_complex_mixer.sv
// Digital downconversion mixer: real ADC samples times the quadrature LO give baseband I/Q.
// Three-stage multiply/round/saturate pipeline feeding a small FWFT output FIFO. Acceptance
// is credit based: samples in flight plus buffered samples never exceed the FIFO depth, so
// the pipeline never has to stall and no accepted sample is dropped.
module ddc_complex_mixer #(
  parameter int unsigned DATA_WIDTH = 16,
  parameter int unsigned NCO_WIDTH  = 16,
  parameter int unsigned OUT_WIDTH  = 16,
  parameter int unsigned FIFO_DEPTH = 4
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  enable_i,
  input  logic [DATA_WIDTH-1:0] adc_data_i,
  input  logic                  adc_valid_i,
  input  logic [NCO_WIDTH-1:0]  nco_sine_i,
  input  logic [NCO_WIDTH-1:0]  nco_cosine_i,
  input  logic                  nco_valid_i,
  output logic                  in_ready_o,
  output logic [OUT_WIDTH-1:0]  i_out_o,
  output logic [OUT_WIDTH-1:0]  q_out_o,
  output logic                  out_valid_o,
  input  logic                  out_ready_i,
  input  logic                  clear_stats_i,
  output logic [15:0]           overflow_count_o
);

  localparam int unsigned ProdW = DATA_WIDTH + NCO_WIDTH;
  localparam int unsigned RndW  = ProdW + 1;
  localparam int unsigned Shift = NCO_WIDTH - 1;
  localparam int unsigned ShW   = RndW - Shift;
  localparam int unsigned PtrW  = $clog2(FIFO_DEPTH);
  localparam int unsigned CntW  = PtrW + 1;
  localparam int unsigned UsedW = CntW + 2;

  localparam logic [NCO_WIDTH-1:0] NcoMin = {1'b1, {(NCO_WIDTH-1){1'b0}}};
  localparam logic [NCO_WIDTH-1:0] NcoMax = {1'b0, {(NCO_WIDTH-1){1'b1}}};
  localparam logic [OUT_WIDTH-1:0] OutMin = {1'b1, {(OUT_WIDTH-1){1'b0}}};
  localparam logic [OUT_WIDTH-1:0] OutMax = {1'b0, {(OUT_WIDTH-1){1'b1}}};
  localparam logic [RndW-1:0]      RndHalf = RndW'(1) << (NCO_WIDTH - 2);

  // Round-half-up, shift back to sample scale, then clamp. Bit OUT_WIDTH flags a clamp.
  function automatic logic [OUT_WIDTH:0] round_sat(input logic [ProdW-1:0] prod);
    logic [RndW-1:0]          rnd;
    logic [ShW-1:0]           sh;
    logic [ShW-OUT_WIDTH:0]   hi;
    logic                     fits;
    rnd  = {prod[ProdW-1], prod} + RndHalf;
    sh   = ShW'(rnd >> Shift);
    hi   = sh[ShW-1:OUT_WIDTH-1];
    fits = (&hi) | ~(|hi);
    if (fits) begin
      round_sat = {1'b0, sh[OUT_WIDTH-1:0]};
    end else begin
      round_sat = {1'b1, (sh[ShW-1] ? OutMin : OutMax)};
    end
  endfunction

  // Pipeline state
  logic                  v1_q, v2_q, v3_q;
  logic [DATA_WIDTH-1:0] x1_q;
  logic [NCO_WIDTH-1:0]  c1_q, s1_q;
  logic [ProdW-1:0]      ip2_q, qp2_q;
  logic [OUT_WIDTH-1:0]  i3_q, q3_q;
  logic                  sat3_q;

  // FIFO state
  logic [OUT_WIDTH-1:0] mem_i_q [FIFO_DEPTH];
  logic [OUT_WIDTH-1:0] mem_q_q [FIFO_DEPTH];
  logic [PtrW-1:0]      wr_ptr_q, rd_ptr_q;
  logic [CntW-1:0]      count_q, count_d;
  logic [15:0]          ovf_q, ovf_d;

  logic                 accept, push, pop;
  logic [UsedW-1:0]     used;
  logic [NCO_WIDTH-1:0] s_neg;
  logic [OUT_WIDTH:0]   i_res, q_res;

  // Credit check uses registered occupancy only; out_ready never reaches in_ready.
  assign used       = UsedW'(count_q) + UsedW'(v1_q) + UsedW'(v2_q) + UsedW'(v3_q);
  assign in_ready_o = enable_i & ~rst_i & (used < UsedW'(FIFO_DEPTH));
  assign accept     = adc_valid_i & nco_valid_i & in_ready_o;

  // -(-full_scale) does not fit, so it clamps to +full_scale.
  assign s_neg = (nco_sine_i == NcoMin) ? NcoMax : (~nco_sine_i + NCO_WIDTH'(1));

  assign i_res = round_sat(ip2_q);
  assign q_res = round_sat(qp2_q);

  assign push        = v3_q;
  assign out_valid_o = (count_q != '0);
  assign pop         = out_valid_o & out_ready_i;
  assign i_out_o     = out_valid_o ? mem_i_q[rd_ptr_q] : '0;
  assign q_out_o     = out_valid_o ? mem_q_q[rd_ptr_q] : '0;
  assign overflow_count_o = ovf_q;

  // Stage valids advance every cycle; backpressure is handled by credit alone.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      v1_q <= 1'b0;
      v2_q <= 1'b0;
      v3_q <= 1'b0;
    end else begin
      v1_q <= accept;
      v2_q <= v1_q;
      v3_q <= v2_q;
    end
  end

  // Datapath: S1 capture, S2 full-width products, S3 rounded and clamped I/Q.
  always_ff @(posedge clk_i) begin
    if (accept) begin
      x1_q <= adc_data_i;
      c1_q <= nco_cosine_i;
      s1_q <= s_neg;
    end
    if (v1_q) begin
      ip2_q <= ProdW'($signed(x1_q)) * ProdW'($signed(c1_q));
      qp2_q <= ProdW'($signed(x1_q)) * ProdW'($signed(s1_q));
    end
    if (v2_q) begin
      i3_q   <= i_res[OUT_WIDTH-1:0];
      q3_q   <= q_res[OUT_WIDTH-1:0];
      sat3_q <= i_res[OUT_WIDTH] | q_res[OUT_WIDTH];
    end
  end

  // Next-state for FIFO occupancy and the sticky overflow counter.
  always_comb begin
    count_d = count_q;
    if (push && !pop) begin
      count_d = count_q + CntW'(1);
    end else if (!push && pop) begin
      count_d = count_q - CntW'(1);
    end
    ovf_d = ovf_q;
    if (clear_stats_i) begin
      ovf_d = '0;
    end else if (push && sat3_q && (ovf_q != 16'hFFFF)) begin
      ovf_d = ovf_q + 16'd1;
    end
  end

  // FIFO pointers, occupancy and statistics.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      ovf_q    <= '0;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + PtrW'(1);
      if (pop)  rd_ptr_q <= rd_ptr_q + PtrW'(1);
      count_q <= count_d;
      ovf_q   <= ovf_d;
    end
  end

  // FIFO storage; not reset because outputs are gated by out_valid.
  always_ff @(posedge clk_i) begin
    if (push) begin
      mem_i_q[wr_ptr_q] <= i3_q;
      mem_q_q[wr_ptr_q] <= q3_q;
    end
  end

  // Credit accounting must make a push into a full FIFO impossible.
  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      assert (!(push && (count_q == CntW'(FIFO_DEPTH))));
    end
  end

endmodule

// File: tb/tb_ddc_complex_mixer.sv
// Scoreboard bench for ddc_complex_mixer: accepted samples push a reference result,
// a negedge monitor compares every presented output and the credit-based in_ready.
module tb_ddc_complex_mixer;

  logic               clk, rst, enable, adc_valid, nco_valid, out_ready, clear_stats;
  logic signed [15:0] adc_data, nco_sine, nco_cosine, i_out, q_out;
  logic               in_ready, out_valid;
  logic [15:0]        overflow_count;

  ddc_complex_mixer #(
    .DATA_WIDTH(16),
    .NCO_WIDTH (16),
    .OUT_WIDTH (16),
    .FIFO_DEPTH(4)
  ) dut (
    .clk_i           (clk),
    .rst_i           (rst),
    .enable_i        (enable),
    .adc_data_i      (adc_data),
    .adc_valid_i     (adc_valid),
    .nco_sine_i      (nco_sine),
    .nco_cosine_i    (nco_cosine),
    .nco_valid_i     (nco_valid),
    .in_ready_o      (in_ready),
    .i_out_o         (i_out),
    .q_out_o         (q_out),
    .out_valid_o     (out_valid),
    .out_ready_i     (out_ready),
    .clear_stats_i   (clear_stats),
    .overflow_count_o(overflow_count)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  typedef struct {
    int i;
    int q;
    bit sat;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0, failures = 0;
  int   acc_cnt = 0, pop_cnt = 0, ovf_model = 0, cyc = 0;
  bit   lat_arm = 1'b0;
  int   lat_acc = -1, lat_out = -1;

  task automatic check(input string name, input int act, input int req);
    checks++;
    if (act != req) begin
      failures++;
      $display("FAIL %s: got %0d, expected %0d", name, act, req);
    end
  endtask

  // Reference: floor((p + 2^14) / 2^15) clamped to the signed 16-bit range.
  function automatic void ref_mul(input longint x, input longint lo, output int res,
                                  output bit sat);
    longint n, q;
    n = x * lo + 16384;
    q = n / 32768;
    if ((n % 32768) != 0 && n < 0) q = q - 1;
    sat = 1'b0;
    if (q > 32767) begin
      q = 32767;
      sat = 1'b1;
    end else if (q < -32768) begin
      q = -32768;
      sat = 1'b1;
    end
    res = int'(q);
  endfunction

  function automatic exp_t ref_mix(input int x, input int c, input int s);
    exp_t e;
    int   sn;
    bit   si, sq;
    sn = (s == -32768) ? 32767 : -s;
    ref_mul(longint'(x), longint'(c), e.i, si);
    ref_mul(longint'(x), longint'(sn), e.q, sq);
    e.sat = si | sq;
    return e;
  endfunction

  function automatic logic signed [15:0] rnd16();
    logic signed [15:0] v;
    case ($urandom_range(0, 7))
      0:       v = -16'sd32768;
      1:       v = 16'sd32767;
      default: v = 16'($urandom);
    endcase
    return v;
  endfunction

  // Monitor / scoreboard, sampling away from the active edge.
  bit   mon_acc, mon_pop, mon_ir;
  exp_t mon_e;
  always @(negedge clk) begin
    cyc++;
    mon_ir = enable && !rst && (exp_q.size() < 4);
    check("in_ready", int'(in_ready), int'(mon_ir));
    if (out_valid === 1'b1) begin
      if (exp_q.size() == 0) begin
        check("unexpected_output", 1, 0);
      end else begin
        checks++;
        if ({i_out, q_out} !== {16'(exp_q[0].i), 16'(exp_q[0].q)}) begin
          failures++;
          $display("FAIL data: got I=%0d Q=%0d, expected I=%0d Q=%0d",
                   i_out, q_out, exp_q[0].i, exp_q[0].q);
        end
      end
      if (lat_arm && lat_out < 0) lat_out = cyc;
    end
    mon_pop = (out_valid === 1'b1) && out_ready && (exp_q.size() > 0);
    mon_acc = adc_valid && nco_valid && enable && (in_ready === 1'b1);
    if (rst) begin
      exp_q.delete();
      ovf_model = 0;
    end else begin
      if (mon_pop) begin
        void'(exp_q.pop_front());
        pop_cnt++;
      end
      if (mon_acc) begin
        mon_e = ref_mix(int'(adc_data), int'(nco_cosine), int'(nco_sine));
        exp_q.push_back(mon_e);
        acc_cnt++;
        if (lat_arm && lat_acc < 0) lat_acc = cyc;
      end
      if (clear_stats) ovf_model = 0;
      else if (mon_acc && mon_e.sat && ovf_model < 65535) ovf_model++;
    end
  end

  task automatic drain();
    int n;
    n = 0;
    adc_valid = 1'b0;
    nco_valid = 1'b0;
    out_ready = 1'b1;
    while (exp_q.size() != 0 && n < 100) begin
      @(posedge clk); #1;
      n++;
    end
    check("drain_empty", exp_q.size(), 0);
    repeat (4) @(posedge clk);
    #1;
  endtask

  task automatic single(input logic signed [15:0] x, c, s, input int ei, eq,
                        input string tag);
    @(posedge clk); #1;
    adc_data = x; nco_cosine = c; nco_sine = s;
    adc_valid = 1'b1; nco_valid = 1'b1; out_ready = 1'b1;
    @(posedge clk); #1;
    adc_valid = 1'b0; nco_valid = 1'b0;
    for (int n = 1; n <= 4; n++) begin
      @(negedge clk);
      check({tag, "_latency"}, int'(out_valid), (n == 4) ? 1 : 0);
    end
    check({tag, "_i"}, int'(i_out), ei);
    check({tag, "_q"}, int'(q_out), eq);
    drain();
  endtask

  initial begin
    int base, pbase, n;
    #500000;
    $display("FAIL watchdog: got time limit reached, expected self-termination");
    $fatal(1, "watchdog");
  end

  initial begin
    int base, pbase, n;
    rst = 1'b1; enable = 1'b0; adc_valid = 1'b0; nco_valid = 1'b0; out_ready = 1'b1;
    clear_stats = 1'b0; adc_data = '0; nco_sine = '0; nco_cosine = '0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_out_valid", int'(out_valid), 0);
    check("rst_i_out", int'(i_out), 0);
    check("rst_q_out", int'(q_out), 0);
    check("rst_ovf", int'(overflow_count), 0);
    check("rst_in_ready", int'(in_ready), 0);
    rst = 1'b0; enable = 1'b1;
    #1;
    check("post_rst_in_ready", int'(in_ready), 1);

    single(16'sd16384, 16'sd32767, 16'sd0, 16384, 0, "pass");
    check("pass_ovf", int'(overflow_count), 0);
    single(-16'sd32768, -16'sd32767, -16'sd32768, 32767, -32767, "quad");
    check("quad_ovf", int'(overflow_count), 0);
    for (int k = 1; k <= 3; k++) begin
      single(-16'sd32768, -16'sd32768, 16'sd0, 32767, 0, "sat");
      check("sat_ovf", int'(overflow_count), k);
    end
    @(posedge clk); #1; clear_stats = 1'b1;
    @(posedge clk); #1; clear_stats = 1'b0;
    check("clear_ovf", int'(overflow_count), 0);

    // Clear lands on the same edge as a saturated push: clear wins.
    @(posedge clk); #1;
    adc_data = -16'sd32768; nco_cosine = -16'sd32768; nco_sine = '0;
    adc_valid = 1'b1; nco_valid = 1'b1;
    @(posedge clk); #1;
    adc_valid = 1'b0; nco_valid = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    clear_stats = 1'b1;
    @(posedge clk); #1;
    clear_stats = 1'b0;
    check("clear_priority_ovf", int'(overflow_count), 0);
    drain();

    // Backpressure: only FIFO_DEPTH samples may be taken while the output is stalled.
    out_ready = 1'b0; adc_valid = 1'b1; nco_valid = 1'b1; enable = 1'b1;
    base = acc_cnt;
    repeat (10) begin
      adc_data = rnd16(); nco_cosine = rnd16(); nco_sine = rnd16();
      @(posedge clk); #1;
    end
    check("bp_accepts", acc_cnt - base, 4);
    check("bp_in_ready", int'(in_ready), 0);

    // Random traffic with random backpressure.
    base = acc_cnt; n = 0;
    while ((acc_cnt - base) < 1000 && n < 20000) begin
      adc_valid = ($urandom_range(0, 3) != 0);
      nco_valid = ($urandom_range(0, 9) != 0);
      enable    = ($urandom_range(0, 9) != 0);
      out_ready = ($urandom_range(0, 1) != 0);
      adc_data = rnd16(); nco_cosine = rnd16(); nco_sine = rnd16();
      @(posedge clk); #1;
      n++;
    end
    check("random_accepts", acc_cnt - base, 1000);
    enable = 1'b1;
    drain();
    check("random_ovf", int'(overflow_count), ovf_model);

    // Back-to-back stream; enable drops before draining to show in-flight work completes.
    base = acc_cnt; pbase = pop_cnt; n = 0;
    lat_acc = -1; lat_out = -1; lat_arm = 1'b1;
    out_ready = 1'b1; enable = 1'b1; adc_valid = 1'b1; nco_valid = 1'b1;
    while ((acc_cnt - base) < 64 && n < 400) begin
      adc_data = rnd16(); nco_cosine = rnd16(); nco_sine = rnd16();
      @(posedge clk); #1;
      n++;
    end
    enable = 1'b0;
    drain();
    lat_arm = 1'b0;
    check("stream_accepts", acc_cnt - base, 64);
    check("stream_pops", pop_cnt - pbase, 64);
    check("stream_first_latency", lat_out - lat_acc, 4);

    // Reset with samples both buffered and in flight.
    enable = 1'b1; out_ready = 1'b0;
    adc_data = -16'sd32768; nco_cosine = -16'sd32768; nco_sine = '0;
    adc_valid = 1'b1; nco_valid = 1'b1;
    repeat (5) @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk); #1;
    check("midrst_out_valid", int'(out_valid), 0);
    check("midrst_ovf", int'(overflow_count), 0);
    check("midrst_in_ready", int'(in_ready), 0);
    rst = 1'b0; adc_valid = 1'b0; nco_valid = 1'b0; out_ready = 1'b1;
    #1;
    check("after_rst_in_ready", int'(in_ready), 1);
    repeat (6) @(posedge clk);
    #1;
    check("after_rst_no_output", int'(out_valid), 0);
    base = acc_cnt; pbase = pop_cnt;
    adc_valid = 1'b1; nco_valid = 1'b1;
    repeat (8) begin
      adc_data = rnd16(); nco_cosine = rnd16(); nco_sine = rnd16();
      @(posedge clk); #1;
    end
    drain();
    check("after_rst_pops", pop_cnt - pbase, acc_cnt - base);
    check("final_ovf", int'(overflow_count), ovf_model);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
